// File: rtl/key_evt_pkg.sv
// Shared constants for the key event arbiter: event codes, key order and defaults.
package key_evt_pkg;

  localparam int unsigned DEBOUNCE_DEF      = 4;
  localparam int unsigned REPEAT_DELAY_DEF  = 16;
  localparam int unsigned REPEAT_PERIOD_DEF = 8;

  localparam int unsigned NUM_KEYS = 4;
  localparam int unsigned CODE_W   = 3;

  // Key index doubles as priority rank: lower index wins.
  localparam int unsigned KEY_EDIT  = 0;
  localparam int unsigned KEY_SWI   = 1;
  localparam int unsigned KEY_PLUS  = 2;
  localparam int unsigned KEY_MINUS = 3;

  typedef enum logic [CODE_W-1:0] {
    EVT_NONE  = 3'd0,
    EVT_EDIT  = 3'd1,
    EVT_SWI   = 3'd2,
    EVT_PLUS  = 3'd3,
    EVT_MINUS = 3'd4
  } evt_code_e;

  function automatic logic [NUM_KEYS-1:0] prio_grant(input logic [NUM_KEYS-1:0] pend);
    logic found;
    prio_grant = '0;
    found      = 1'b0;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      if (pend[i] && !found) begin
        prio_grant[i] = 1'b1;
        found         = 1'b1;
      end
    end
  endfunction

  function automatic evt_code_e code_of(input logic [NUM_KEYS-1:0] grant);
    code_of = EVT_NONE;
    if (grant[KEY_EDIT])       code_of = EVT_EDIT;
    else if (grant[KEY_SWI])   code_of = EVT_SWI;
    else if (grant[KEY_PLUS])  code_of = EVT_PLUS;
    else if (grant[KEY_MINUS]) code_of = EVT_MINUS;
  endfunction

endpackage

// File: rtl/key_event_arbiter_if.sv
// Event handshake between the key arbiter (master) and its consumer (slave).
interface key_event_arbiter_if;
  logic                   evt_valid;
  key_evt_pkg::evt_code_e evt_code;
  logic                   evt_ready;
  logic                   evt_drop;

  modport master (output evt_valid, output evt_code, output evt_drop, input evt_ready);
  modport slave  (input evt_valid, input evt_code, input evt_drop, output evt_ready);
endinterface

// File: rtl/key_debounce.sv
// Per-key 2-flop synchronizer, debounce filter and optional auto-repeat timer.
// Emits a one-cycle press pulse on a debounced press and on each repeat.
module key_debounce
  import key_evt_pkg::*;
#(
  parameter int unsigned DEBOUNCE      = DEBOUNCE_DEF,
  parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF,
  parameter bit          REPEAT_EN     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int unsigned DW = $clog2(DEBOUNCE + 1);
  localparam int unsigned RW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);

  logic [1:0]    sync_q, sync_d;
  logic          deb_q, deb_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rpt_q, rpt_d;
  logic          armed_q, armed_d;
  logic          press_q, press_d;

  always_comb begin
    sync_d  = {sync_q[0], key_n};
    deb_d   = deb_q;
    cnt_d   = '0;
    rpt_d   = '0;
    armed_d = 1'b0;
    press_d = 1'b0;

    if (sync_q[1] != deb_q) begin
      if (cnt_q == DW'(DEBOUNCE - 1)) deb_d = sync_q[1];
      else                            cnt_d = cnt_q + DW'(1);
    end

    // Repeats only while the key stays down through this edge, so a release stops them at once.
    if (deb_q && !deb_d) begin
      press_d = 1'b1;
    end else if (REPEAT_EN && !deb_q && !deb_d) begin
      rpt_d   = rpt_q + RW'(1);
      armed_d = armed_q;
      if (rpt_d == (armed_q ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY))) begin
        press_d = 1'b1;
        rpt_d   = '0;
        armed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 2'b11;
      deb_q   <= 1'b1;
      cnt_q   <= '0;
      rpt_q   <= '0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      rpt_q   <= rpt_d;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/key_event_arbiter.sv
// Debounces four active-low buttons and serialises their press events through
// a pending-bit priority arbiter into a single-register valid/ready output.
module key_event_arbiter
  import key_evt_pkg::*;
#(
  parameter int unsigned DEBOUNCE      = DEBOUNCE_DEF,
  parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       KeyEdit,
  input  logic                       KeySwi,
  input  logic                       KeyPlus,
  input  logic                       KeyMinus,
  key_event_arbiter_if.master        evt
);

  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] pend_q, pend_d;
  logic [NUM_KEYS-1:0] grant;
  logic                load;
  logic                valid_q, valid_d;
  evt_code_e           code_q, code_d;
  logic                drop_q, drop_d;

  key_debounce #(.DEBOUNCE(DEBOUNCE), .REPEAT_DELAY(REPEAT_DELAY),
                 .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b0))
    u_edit  (.clk(clk), .reset(reset), .key_n(KeyEdit),  .press(press[KEY_EDIT]));
  key_debounce #(.DEBOUNCE(DEBOUNCE), .REPEAT_DELAY(REPEAT_DELAY),
                 .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b0))
    u_swi   (.clk(clk), .reset(reset), .key_n(KeySwi),   .press(press[KEY_SWI]));
  key_debounce #(.DEBOUNCE(DEBOUNCE), .REPEAT_DELAY(REPEAT_DELAY),
                 .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1))
    u_plus  (.clk(clk), .reset(reset), .key_n(KeyPlus),  .press(press[KEY_PLUS]));
  key_debounce #(.DEBOUNCE(DEBOUNCE), .REPEAT_DELAY(REPEAT_DELAY),
                 .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1))
    u_minus (.clk(clk), .reset(reset), .key_n(KeyMinus), .press(press[KEY_MINUS]));

  // Grant looks only at registered pending bits, so a fresh press waits one edge.
  always_comb begin
    grant   = prio_grant(pend_q);
    load    = !valid_q || evt.evt_ready;
    valid_d = valid_q;
    code_d  = code_q;
    pend_d  = (pend_q & ~(load ? grant : '0)) | (press & ~pend_q);
    drop_d  = |(press & pend_q);
    if (load) begin
      valid_d = |grant;
      code_d  = code_of(grant);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q  <= '0;
      valid_q <= 1'b0;
      code_q  <= EVT_NONE;
      drop_q  <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      drop_q  <= drop_d;
    end
  end

  assign evt.evt_valid = valid_q;
  assign evt.evt_code  = code_q;
  assign evt.evt_drop  = drop_q;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Scoreboard bench for key_event_arbiter: expected events are queued with their
// cycle of appearance and matched against every accepted transfer.
module tb_key_event_arbiter;

  typedef struct {
    logic [2:0] code;
    int         cyc;   // -1: cycle not checked
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic key_edit, key_swi, key_plus, key_minus;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   drop_cnt = 0;
  exp_t sb[$];

  key_event_arbiter_if evt_if ();

  key_event_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .KeyEdit  (key_edit),
    .KeySwi   (key_swi),
    .KeyPlus  (key_plus),
    .KeyMinus (key_minus),
    .evt      (evt_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transfer monitor: every accepted event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (evt_if.evt_drop === 1'b1) drop_cnt++;
    if (reset === 1'b0 && evt_if.evt_valid === 1'b1 && evt_if.evt_ready === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_evt: got code=%0d at cyc=%0d, required no event", evt_if.evt_code, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (evt_if.evt_code !== e.code) begin
          bad++;
          $display("FAIL evt_code: got %0d, required %0d (cyc=%0d)", evt_if.evt_code, e.code, cyc);
        end
        if (e.cyc >= 0) begin
          total++;
          if (cyc !== e.cyc) begin
            bad++;
            $display("FAIL evt_cycle: code %0d got cyc=%0d, required cyc=%0d", e.code, cyc, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check_idle_outputs(input string name);
    @(negedge clk);
    total++;
    if (evt_if.evt_valid !== 1'b0 || evt_if.evt_code !== 3'd0 || evt_if.evt_drop !== 1'b0) begin
      bad++;
      $display("FAIL %s: got valid=%b code=%0d drop=%b, required 0/0/0",
               name, evt_if.evt_valid, evt_if.evt_code, evt_if.evt_drop);
    end
  endtask

  task automatic check_sb_empty(input string name);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d expected events never seen, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    key_edit = 1'b1; key_swi = 1'b1; key_plus = 1'b1; key_minus = 1'b1;
    evt_if.evt_ready = 1'b1;
    repeat (3) @(posedge clk);
    check_idle_outputs("reset_outputs");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    check_idle_outputs("post_reset_idle");
  endtask

  // Plus low for 10 cycles: one event, first-sample-to-valid latency 8.
  task automatic test_single_plus();
    int b;
    @(posedge clk); #1;
    b = cyc;
    key_plus = 1'b0;
    sb.push_back('{3'd3, b + 8});
    repeat (10) @(posedge clk); #1;
    key_plus = 1'b1;
    repeat (40) @(posedge clk);
    check_sb_empty("single_plus_done");
  endtask

  task automatic test_simultaneous();
    int b;
    @(posedge clk); #1;
    b = cyc;
    key_edit = 1'b0; key_swi = 1'b0; key_minus = 1'b0;
    sb.push_back('{3'd1, b + 8});
    sb.push_back('{3'd2, b + 9});
    sb.push_back('{3'd4, b + 10});
    repeat (10) @(posedge clk); #1;
    key_edit = 1'b1; key_swi = 1'b1; key_minus = 1'b1;
    repeat (30) @(posedge clk);
    check_sb_empty("simultaneous_done");
  endtask

  // Minus held 30 cycles: press, one delayed repeat, one periodic repeat, nothing after release.
  task automatic test_repeat();
    int b;
    @(posedge clk); #1;
    b = cyc;
    key_minus = 1'b0;
    sb.push_back('{3'd4, b + 8});
    sb.push_back('{3'd4, b + 24});
    sb.push_back('{3'd4, b + 32});
    repeat (30) @(posedge clk); #1;
    key_minus = 1'b1;
    repeat (50) @(posedge clk);
    check_sb_empty("repeat_done");
  endtask

  // Three Swi presses under backpressure: one held in output, one pending, one dropped.
  task automatic test_back_pressure();
    evt_if.evt_ready = 1'b0;
    drop_cnt = 0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      key_swi = 1'b0;
      repeat (8) @(posedge clk); #1;
      key_swi = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      total++;
      if (evt_if.evt_valid !== 1'b1 || evt_if.evt_code !== 3'd2) begin
        bad++;
        $display("FAIL hold_steady_%0d: got valid=%b code=%0d, required 1/2", n, evt_if.evt_valid, evt_if.evt_code);
      end
    end
    total++;
    if (drop_cnt != 1) begin
      bad++;
      $display("FAIL drop_pulses: got %0d, required 1", drop_cnt);
    end
    sb.push_back('{3'd2, -1});
    sb.push_back('{3'd2, -1});
    @(posedge clk); #1;
    evt_if.evt_ready = 1'b1;
    repeat (10) @(posedge clk);
    check_sb_empty("back_pressure_done");
    check_idle_outputs("back_pressure_idle");
  endtask

  task automatic test_glitch();
    @(posedge clk); #1;
    key_edit = 1'b0;
    repeat (3) @(posedge clk); #1;
    key_edit = 1'b1;
    repeat (30) @(posedge clk);
    check_idle_outputs("glitch_no_event");
  endtask

  // Reset lands the edge after the pending bit sets: the event is lost.
  task automatic test_reset_mid();
    @(posedge clk); #1;
    key_edit = 1'b0;
    repeat (7) @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    key_edit = 1'b1;
    check_idle_outputs("reset_mid_outputs");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (30) @(posedge clk);
    check_idle_outputs("reset_mid_no_event");
  endtask

  // Key already low when reset releases still yields exactly one press.
  task automatic test_hold_through_reset();
    int b;
    @(posedge clk); #1;
    key_swi = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk); #1;
    b = cyc;
    reset = 1'b0;
    sb.push_back('{3'd2, b + 8});
    repeat (12) @(posedge clk); #1;
    key_swi = 1'b1;
    repeat (30) @(posedge clk);
    check_sb_empty("hold_through_reset_done");
  endtask

  initial begin
    test_reset();
    test_single_plus();
    test_simultaneous();
    test_repeat();
    test_back_pressure();
    test_glitch();
    test_reset_mid();
    test_hold_through_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
